// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register plus operand selection for the RISC-V core.
//   Captures decoded operands/control, applies flush/stall/load-use bubble
//   insertion, and resolves EX/MEM and MEM/WB forwarding into the ALU inputs.
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_*                  : decoded instruction fields from the ID stage
//   stall, flush          : hold / bubble the ID/EX register
//   exmem_*, memwb_*      : forwarding sources (write enable, rd, data)
//   in1, in2              : ALU operands (combinational, forwarded)
//   alu_op, ex_*          : registered control and PC for EX/MEM
//   ex_store_data         : forwarded rs2, independent of operand-2 select
//   load_use_stall        : request to upstream to hold PC and IF/ID
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src1_sel,
    input  logic            id_src2_sel,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd_addr,
    input  logic [XLEN-1:0] exmem_alu_out,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd_addr,
    input  logic [XLEN-1:0] memwb_wb_data,
    output logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] in2,
    output logic [3:0]      alu_op,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);

    logic            r_valid;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_src1_sel;
    logic            r_src2_sel;
    logic [3:0]      r_alu_op;
    logic [4:0]      r_rd_addr;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;

    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_load_use;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // rs2 matters for stores even when operand 2 is the immediate.
    always_comb begin
        w_rs1_hit  = !id_src1_sel && (id_rs1_addr == r_rd_addr);
        w_rs2_hit  = (!id_src2_sel || id_mem_write) && (id_rs2_addr == r_rd_addr);
        w_load_use = r_valid && r_mem_read && (r_rd_addr != 5'd0) && id_valid
                     && (w_rs1_hit || w_rs2_hit);
    end

    // EX/MEM is the younger result and wins over MEM/WB; x0 never forwards.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exmem_reg_write && (exmem_rd_addr != 5'd0) && (exmem_rd_addr == r_rs1_addr))
            w_fwd_rs1 = exmem_alu_out;
        else if (memwb_reg_write && (memwb_rd_addr != 5'd0) && (memwb_rd_addr == r_rs1_addr))
            w_fwd_rs1 = memwb_wb_data;

        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && (exmem_rd_addr != 5'd0) && (exmem_rd_addr == r_rs2_addr))
            w_fwd_rs2 = exmem_alu_out;
        else if (memwb_reg_write && (memwb_rd_addr != 5'd0) && (memwb_rd_addr == r_rs2_addr))
            w_fwd_rs2 = memwb_wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || (!stall && w_load_use)) begin
            // Bubble: clearing the source addresses to x0 also blocks forwarding,
            // so in1/in2/ex_store_data read back as 0.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_src1_sel  <= 1'b0;
            r_src2_sel  <= 1'b0;
            r_alu_op    <= '0;
            r_rd_addr   <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
        end else if (!stall) begin
            r_valid     <= id_valid;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_src1_sel  <= id_src1_sel;
            r_src2_sel  <= id_src2_sel;
            r_alu_op    <= id_alu_op;
            r_rd_addr   <= id_rd_addr;
            r_rs1_addr  <= id_rs1_addr;
            r_rs2_addr  <= id_rs2_addr;
            r_pc        <= id_pc;
            r_imm       <= id_imm;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
        end
    end

    assign in1            = r_src1_sel ? r_pc  : w_fwd_rs1;
    assign in2            = r_src2_sel ? r_imm : w_fwd_rs2;
    assign ex_store_data  = w_fwd_rs2;
    assign alu_op         = r_alu_op;
    assign ex_valid       = r_valid;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_rd_addr     = r_rd_addr;
    assign ex_pc          = r_pc;
    assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_op;
    logic        id_src1_sel, id_src2_sel, id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd_addr;
    logic [31:0] exmem_alu_out;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] memwb_wb_data;
    logic [31:0] in1, in2, ex_pc, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd_addr;
    logic        load_use_stall;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_op(id_alu_op), .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
        .exmem_alu_out(exmem_alu_out),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
        .memwb_wb_data(memwb_wb_data),
        .in1(in1), .in2(in2), .alu_op(alu_op), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic        v, rw, mr, mw, s1, s2;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc, imm, d1, d2;
    } instr_t;

    instr_t m;

    function automatic instr_t id_instr();
        instr_t t;
        t = '{v: id_valid, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
              s1: id_src1_sel, s2: id_src2_sel, op: id_alu_op, rd: id_rd_addr,
              rs1: id_rs1_addr, rs2: id_rs2_addr, pc: id_pc, imm: id_imm,
              d1: id_rs1_data, d2: id_rs2_data};
        return t;
    endfunction

    // Value of register r as seen in EX, given the freshest in-flight writer.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (exmem_reg_write && exmem_rd_addr == r) return exmem_alu_out;
        if (memwb_reg_write && memwb_rd_addr == r) return memwb_wb_data;
        return rf;
    endfunction

    function automatic logic exp_lus();
        logic needs1, needs2;
        needs1 = !id_src1_sel && id_rs1_addr == m.rd;
        needs2 = (!id_src2_sel || id_mem_write) && id_rs2_addr == m.rd;
        return m.v && m.mr && m.rd != 0 && id_valid && (needs1 || needs2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 m <= '0;
        else if (flush)             m <= '0;
        else if (stall)             m <= m;
        else if (exp_lus())         m <= '0;
        else                        m <= id_instr();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model, once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in1", in1, m.s1 ? m.pc : reg_value(m.rs1, m.d1));
            chk("in2", in2, m.s2 ? m.imm : reg_value(m.rs2, m.d2));
            chk("store_data", ex_store_data, reg_value(m.rs2, m.d2));
            chk("alu_op", 32'(alu_op), 32'(m.op));
            chk("ex_ctrl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
                {28'd0, m.v, m.rw, m.mr, m.mw});
            chk("ex_rd", 32'(ex_rd_addr), 32'(m.rd));
            chk("ex_pc", ex_pc, m.pc);
            chk("lus", 32'(load_use_stall), 32'(exp_lus()));
        end
    end

    task automatic clear_in();
        id_valid = 0; id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_op = 0;
        id_src1_sel = 0; id_src2_sel = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        stall = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_alu_out = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_wb_data = 0;
    endtask

    task automatic rand_in();
        id_valid     = ($urandom_range(0, 9) != 0);
        id_pc        = $urandom; id_imm = $urandom;
        id_rs1_data  = $urandom; id_rs2_data = $urandom;
        id_rs1_addr  = 5'($urandom_range(0, 7));
        id_rs2_addr  = 5'($urandom_range(0, 7));
        id_rd_addr   = 5'($urandom_range(0, 7));
        id_alu_op    = 4'($urandom);
        id_src1_sel  = ($urandom_range(0, 3) == 0);
        id_src2_sel  = ($urandom_range(0, 2) == 0);
        id_reg_write = 1'($urandom);
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_mem_write = !id_mem_read && ($urandom_range(0, 3) == 0);
        stall        = ($urandom_range(0, 7) == 0);
        flush        = ($urandom_range(0, 15) == 0);
        exmem_reg_write = 1'($urandom);
        exmem_rd_addr   = 5'($urandom_range(0, 7));
        exmem_alu_out   = $urandom;
        memwb_reg_write = 1'($urandom);
        memwb_rd_addr   = 5'($urandom_range(0, 7));
        memwb_wb_data   = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] save_pc;
    logic [3:0]  save_op;
    logic [4:0]  save_rd;

    initial begin
        // Reset with arbitrary inputs.
        rst_n = 0;
        rand_in();
        stall = 0; flush = 0;
        #7;
        chk_en = 1;
        chk("rst_in1", in1, 32'h0);
        chk("rst_in2", in2, 32'h0);
        chk("rst_store", ex_store_data, 32'h0);
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_lus", 32'(load_use_stall), 32'h0);
        #1;
        rst_n = 1;
        clear_in();

        // ADD with rs1=0x1A, rs2=0x0D.
        id_valid = 1; id_reg_write = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3;
        id_rs1_data = 32'h1A; id_rs2_data = 32'h0D;
        step();
        chk("add_in1", in1, 32'h1A);
        chk("add_in2", in2, 32'h0D);
        chk("add_valid", 32'(ex_valid), 32'h1);

        // Forwarding priority on rs1 = x5.
        id_rs1_addr = 5; id_rs1_data = 32'h55;
        step();
        stall = 1;
        exmem_reg_write = 1; exmem_rd_addr = 5; exmem_alu_out = 32'h11111111;
        memwb_reg_write = 1; memwb_rd_addr = 5; memwb_wb_data = 32'h22222222;
        #1 chk("fwd_exmem", in1, 32'h11111111);
        exmem_reg_write = 0;
        #1 chk("fwd_memwb", in1, 32'h22222222);
        exmem_reg_write = 1; exmem_rd_addr = 0; memwb_rd_addr = 0;
        #1 chk("fwd_x0", in1, 32'h55);
        clear_in();

        // PC / immediate select; store data still forwarded rs2.
        id_valid = 1; id_src1_sel = 1; id_src2_sel = 1; id_pc = 32'h100;
        id_imm = 32'hFFFFF82F; id_rs2_addr = 6; id_rs2_data = 32'h66; id_mem_write = 1;
        step();
        exmem_reg_write = 1; exmem_rd_addr = 6; exmem_alu_out = 32'hABCD;
        #1;
        chk("sel_in1", in1, 32'h100);
        chk("sel_in2", in2, 32'hFFFFF82F);
        chk("sel_store", ex_store_data, 32'hABCD);
        clear_in();

        // Load-use: LW x7 then ADD x8,x7,x3.
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 7;
        step();
        clear_in();
        id_valid = 1; id_reg_write = 1; id_rs1_addr = 7; id_rs2_addr = 3; id_rd_addr = 8;
        id_rs1_data = 32'hDEAD; id_rs2_data = 32'h3;
        #1 chk("lu_stall", 32'(load_use_stall), 32'h1);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_once", 32'(load_use_stall), 32'h0);
        step();
        memwb_reg_write = 1; memwb_rd_addr = 7; memwb_wb_data = 32'h77777777;
        #1;
        chk("lu_valid", 32'(ex_valid), 32'h1);
        chk("lu_in1", in1, 32'h77777777);
        clear_in();

        // Stall for 3 cycles with changing inputs.
        id_valid = 1; id_alu_op = 4'h9; id_pc = 32'h200; id_rd_addr = 4;
        step();
        save_pc = ex_pc; save_op = alu_op; save_rd = ex_rd_addr;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            stall = 1; flush = 0;
            exmem_reg_write = 0; memwb_reg_write = 0;
            step();
            chk("stall_pc", ex_pc, save_pc);
            chk("stall_op", 32'(alu_op), 32'(save_op));
            chk("stall_rd", 32'(ex_rd_addr), 32'(save_rd));
        end
        stall = 1; flush = 1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_op", 32'(alu_op), 32'h0);
        clear_in();

        // Asynchronous mid-cycle reset.
        id_valid = 1; id_pc = 32'h300; id_alu_op = 4'h3; id_rs1_data = 32'h5;
        step();
        chk("mr_valid_pre", 32'(ex_valid), 32'h1);
        rst_n = 0;
        #1;
        chk("mr_valid", 32'(ex_valid), 32'h0);
        chk("mr_pc", ex_pc, 32'h0);
        chk("mr_in1", in1, 32'h0);
        rst_n = 1;

        // Randomized phase, model checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            step();
            rand_in();
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 0;
                #1 rst_n = 1;
            end
        end
        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
